// File: rtl/cuckoo_sched_pkg.sv
// Shared types and default sizing for the cuckoo hash insert scheduler.
package cuckoo_sched_pkg;

    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_KEY_WIDTH  = 2;
    localparam int DEF_NUM_REQ    = 2;
    localparam int DEF_MAX_KICKS  = 8;
    localparam int DEF_PIPE_DEPTH = 4;

    typedef enum logic [1:0] {
        LOOKUP = 2'd0,
        INSERT = 2'd1,
        DELETE = 2'd2
    } op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        REISSUE = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef struct packed {
        logic [DEF_KEY_WIDTH-1:0]  key;
        logic [DEF_DATA_WIDTH-1:0] data;
    } entry_t;

    // Width helper that never collapses to zero bits.
    function automatic int width_of(input int max_value);
        return (max_value > 1) ? $clog2(max_value + 1) : 1;
    endfunction

endpackage

// File: rtl/cuckoo_insert_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among active requests, pointer moves past the winner.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   ptr_reg;
    logic [PTR_W-1:0]   ptr_next;
    logic [NUM_REQ-1:0] mask_hi;
    logic [NUM_REQ-1:0] pick_hi;
    logic [NUM_REQ-1:0] pick_any;

    // Requests at or above the pointer win over wrapped-around ones.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign mask_hi[gi] = req[gi] && (gi >= int'(ptr_reg));
        end
    endgenerate

    assign pick_hi  = mask_hi & (~mask_hi + NUM_REQ'(1));
    assign pick_any = req & (~req + NUM_REQ'(1));

    always_comb begin
        grant = '0;
        if (en) begin
            grant = (|mask_hi) ? pick_hi : pick_any;
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                ptr_next = PTR_W'((k + 1) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg <= '0;
        end else if (|grant) begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/cuckoo_insert_scheduler.sv
// Front-end scheduler for the cuckoo table pipeline: arbitrates requests, re-issues
// evicted entries as inserts and reports the outcome of every insert chain.
module cuckoo_insert_scheduler
    import cuckoo_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int KEY_WIDTH  = DEF_KEY_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int MAX_KICKS  = DEF_MAX_KICKS,
    parameter int PIPE_DEPTH = DEF_PIPE_DEPTH
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                clk_en,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    input  logic [NUM_REQ-1:0][1:0]             req_op_i,
    input  logic [NUM_REQ-1:0][KEY_WIDTH-1:0]   req_key_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    input  logic                                evict_valid_i,
    input  logic [KEY_WIDTH-1:0]                evict_key_i,
    input  logic [DATA_WIDTH-1:0]               evict_data_i,
    output logic                                issue_valid_o,
    output logic [1:0]                          issue_op_o,
    output logic [KEY_WIDTH-1:0]                issue_key_o,
    output logic [DATA_WIDTH-1:0]               issue_data_o,
    output logic                                issue_reinsert_o,
    output logic                                done_valid_o,
    output logic                                done_fail_o,
    output logic [KEY_WIDTH-1:0]                done_key_o,
    output logic [DATA_WIDTH-1:0]               done_data_o,
    output logic                                busy_o
);

    localparam int KICK_W  = width_of(MAX_KICKS);
    localparam int TIMER_W = width_of(PIPE_DEPTH);

    state_t                  state_reg;
    logic [KICK_W-1:0]       kicks_reg;
    logic [TIMER_W-1:0]      timer_reg;
    logic                    fail_reg;
    logic [KEY_WIDTH-1:0]    origin_key_reg;
    logic [DATA_WIDTH-1:0]   origin_data_reg;
    logic [KEY_WIDTH-1:0]    evict_key_reg;
    logic [DATA_WIDTH-1:0]   evict_data_reg;

    logic                    issue_valid_reg;
    logic [1:0]              issue_op_reg;
    logic [KEY_WIDTH-1:0]    issue_key_reg;
    logic [DATA_WIDTH-1:0]   issue_data_reg;
    logic                    issue_reinsert_reg;
    logic                    done_valid_reg;
    logic                    done_fail_reg;
    logic [KEY_WIDTH-1:0]    done_key_reg;
    logic [DATA_WIDTH-1:0]   done_data_reg;

    logic [NUM_REQ-1:0]      grant;
    logic                    arb_en;
    logic                    accept;
    logic [1:0]              sel_op;
    logic [KEY_WIDTH-1:0]    sel_key;
    logic [DATA_WIDTH-1:0]   sel_data;

    // Grants only while idle, enabled and out of reset.
    assign arb_en = clk_en && !reset && (state_reg == IDLE);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (arb_en),
        .req   (req_valid_i),
        .grant (grant)
    );

    assign req_ready_o = grant;
    assign accept      = |grant;

    always_comb begin
        sel_op   = '0;
        sel_key  = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                sel_op   = req_op_i[k];
                sel_key  = req_key_i[k];
                sel_data = req_data_i[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= IDLE;
            kicks_reg          <= '0;
            timer_reg          <= '0;
            fail_reg           <= 1'b0;
            origin_key_reg     <= '0;
            origin_data_reg    <= '0;
            evict_key_reg      <= '0;
            evict_data_reg     <= '0;
            issue_valid_reg    <= 1'b0;
            issue_op_reg       <= '0;
            issue_key_reg      <= '0;
            issue_data_reg     <= '0;
            issue_reinsert_reg <= 1'b0;
            done_valid_reg     <= 1'b0;
            done_fail_reg      <= 1'b0;
            done_key_reg       <= '0;
            done_data_reg      <= '0;
        end else begin
            // Pulses last one cycle; a frozen cycle never repeats them.
            issue_valid_reg <= 1'b0;
            done_valid_reg  <= 1'b0;
            if (clk_en) begin
                case (state_reg)
                    IDLE: begin
                        if (accept) begin
                            issue_valid_reg    <= 1'b1;
                            issue_op_reg       <= sel_op;
                            issue_key_reg      <= sel_key;
                            issue_data_reg     <= sel_data;
                            issue_reinsert_reg <= 1'b0;
                            if (sel_op == INSERT) begin
                                origin_key_reg  <= sel_key;
                                origin_data_reg <= sel_data;
                                kicks_reg       <= '0;
                                timer_reg       <= TIMER_W'(PIPE_DEPTH);
                                fail_reg        <= 1'b0;
                                state_reg       <= WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        if (timer_reg != '0) begin
                            timer_reg <= timer_reg - TIMER_W'(1);
                        end
                        // An eviction on the last window cycle still counts.
                        if (evict_valid_i) begin
                            evict_key_reg  <= evict_key_i;
                            evict_data_reg <= evict_data_i;
                            if (kicks_reg == KICK_W'(MAX_KICKS)) begin
                                fail_reg  <= 1'b1;
                                state_reg <= DONE;
                            end else begin
                                state_reg <= REISSUE;
                            end
                        end else if (timer_reg <= TIMER_W'(1)) begin
                            state_reg <= DONE;
                        end
                    end
                    REISSUE: begin
                        issue_valid_reg    <= 1'b1;
                        issue_op_reg       <= INSERT;
                        issue_key_reg      <= evict_key_reg;
                        issue_data_reg     <= evict_data_reg;
                        issue_reinsert_reg <= 1'b1;
                        kicks_reg          <= kicks_reg + KICK_W'(1);
                        timer_reg          <= TIMER_W'(PIPE_DEPTH);
                        state_reg          <= WAIT;
                    end
                    DONE: begin
                        done_valid_reg <= 1'b1;
                        done_fail_reg  <= fail_reg;
                        done_key_reg   <= fail_reg ? evict_key_reg  : origin_key_reg;
                        done_data_reg  <= fail_reg ? evict_data_reg : origin_data_reg;
                        state_reg      <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign issue_valid_o    = issue_valid_reg;
    assign issue_op_o       = issue_op_reg;
    assign issue_key_o      = issue_key_reg;
    assign issue_data_o     = issue_data_reg;
    assign issue_reinsert_o = issue_reinsert_reg;
    assign done_valid_o     = done_valid_reg;
    assign done_fail_o      = done_fail_reg;
    assign done_key_o       = done_key_reg;
    assign done_data_o      = done_data_reg;
    assign busy_o           = (state_reg != IDLE);

endmodule

// File: tb/tb_cuckoo_insert_scheduler.sv
// Scoreboard bench: stimulus queues expected issues/completions, a negedge monitor checks them.
module tb_cuckoo_insert_scheduler;
    import cuckoo_sched_pkg::*;

    localparam int DW = 4;
    localparam int KW = 2;
    localparam int NR = 2;
    localparam int MK = 2;
    localparam int PD = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     clk_en;
    logic [NR-1:0]            req_valid_i;
    logic [NR-1:0][1:0]       req_op_i;
    logic [NR-1:0][KW-1:0]    req_key_i;
    logic [NR-1:0][DW-1:0]    req_data_i;
    logic [NR-1:0]            req_ready_o;
    logic                     evict_valid_i;
    logic [KW-1:0]            evict_key_i;
    logic [DW-1:0]            evict_data_i;
    logic                     issue_valid_o;
    logic [1:0]               issue_op_o;
    logic [KW-1:0]            issue_key_o;
    logic [DW-1:0]            issue_data_o;
    logic                     issue_reinsert_o;
    logic                     done_valid_o;
    logic                     done_fail_o;
    logic [KW-1:0]            done_key_o;
    logic [DW-1:0]            done_data_o;
    logic                     busy_o;

    cuckoo_insert_scheduler #(
        .DATA_WIDTH (DW),
        .KEY_WIDTH  (KW),
        .NUM_REQ    (NR),
        .MAX_KICKS  (MK),
        .PIPE_DEPTH (PD)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .clk_en           (clk_en),
        .req_valid_i      (req_valid_i),
        .req_op_i         (req_op_i),
        .req_key_i        (req_key_i),
        .req_data_i       (req_data_i),
        .req_ready_o      (req_ready_o),
        .evict_valid_i    (evict_valid_i),
        .evict_key_i      (evict_key_i),
        .evict_data_i     (evict_data_i),
        .issue_valid_o    (issue_valid_o),
        .issue_op_o       (issue_op_o),
        .issue_key_o      (issue_key_o),
        .issue_data_o     (issue_data_o),
        .issue_reinsert_o (issue_reinsert_o),
        .done_valid_o     (done_valid_o),
        .done_fail_o      (done_fail_o),
        .done_key_o       (done_key_o),
        .done_data_o      (done_data_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]    op;
        logic [KW-1:0] key;
        logic [DW-1:0] data;
        logic          re;
        int            at;
    } iss_t;

    typedef struct {
        logic          fail;
        logic [KW-1:0] key;
        logic [DW-1:0] data;
        int            at;
    } done_t;

    iss_t  iss_q[$];
    done_t done_q[$];
    iss_t  ie;
    done_t de;
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) tick();
    endtask

    task automatic push_iss(input logic [1:0] op, input logic [KW-1:0] key,
                            input logic [DW-1:0] data, input logic re, input int at);
        iss_q.push_back('{op, key, data, re, at});
    endtask

    task automatic push_done(input logic fail, input logic [KW-1:0] key,
                             input logic [DW-1:0] data, input int at);
        done_q.push_back('{fail, key, data, at});
    endtask

    // Single requester presents one op; it must be granted in this cycle.
    task automatic single_req(input int idx, input logic [1:0] op, input logic [KW-1:0] key,
                              input logic [DW-1:0] data, output int t);
        logic [NR-1:0] exp_grant;
        exp_grant      = '0;
        exp_grant[idx] = 1'b1;
        req_valid_i    = exp_grant;
        req_op_i[idx]  = op;
        req_key_i[idx] = key;
        req_data_i[idx] = data;
        #1;
        check("grant_single", 32'(req_ready_o), 32'(exp_grant));
        t = cyc;
        push_iss(op, key, data, 1'b0, t + 1);
        tick();
        req_valid_i = '0;
    endtask

    task automatic evict(input logic [KW-1:0] key, input logic [DW-1:0] data);
        evict_valid_i = 1'b1;
        evict_key_i   = key;
        evict_data_i  = data;
        tick();
        evict_valid_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (issue_valid_o) begin
            checks++;
            if (iss_q.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: got op=%0d key=%0d data=%0h re=%0b at cyc %0d required no issue",
                         issue_op_o, issue_key_o, issue_data_o, issue_reinsert_o, cyc);
            end else begin
                ie = iss_q.pop_front();
                if (issue_op_o !== ie.op || issue_key_o !== ie.key || issue_data_o !== ie.data ||
                    issue_reinsert_o !== ie.re || cyc != ie.at) begin
                    errors++;
                    $display("FAIL issue: got op=%0d key=%0d data=%0h re=%0b cyc=%0d required op=%0d key=%0d data=%0h re=%0b cyc=%0d",
                             issue_op_o, issue_key_o, issue_data_o, issue_reinsert_o, cyc,
                             ie.op, ie.key, ie.data, ie.re, ie.at);
                end else begin
                    $display("issue cyc=%0d op=%0d key=%0d data=%0h re=%0b ok",
                             cyc, issue_op_o, issue_key_o, issue_data_o, issue_reinsert_o);
                end
            end
        end
        if (done_valid_o) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got fail=%0b key=%0d data=%0h at cyc %0d required no done",
                         done_fail_o, done_key_o, done_data_o, cyc);
            end else begin
                de = done_q.pop_front();
                if (done_fail_o !== de.fail || done_key_o !== de.key || done_data_o !== de.data ||
                    cyc != de.at) begin
                    errors++;
                    $display("FAIL done: got fail=%0b key=%0d data=%0h cyc=%0d required fail=%0b key=%0d data=%0h cyc=%0d",
                             done_fail_o, done_key_o, done_data_o, cyc, de.fail, de.key, de.data, de.at);
                end else begin
                    $display("done cyc=%0d fail=%0b key=%0d data=%0h ok",
                             cyc, done_fail_o, done_key_o, done_data_o);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        reset         = 1'b1;
        clk_en        = 1'b1;
        req_valid_i   = '0;
        req_op_i      = '0;
        req_key_i     = '0;
        req_data_i    = '0;
        evict_valid_i = 1'b0;
        evict_key_i   = '0;
        evict_data_i  = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state, including no grant while reset is held.
        req_valid_i = 2'b11;
        #1;
        check("rst_ready", 32'(req_ready_o), 32'h0);
        check("rst_issue_valid", 32'(issue_valid_o), 32'h0);
        check("rst_issue_op", 32'(issue_op_o), 32'h0);
        check("rst_issue_key", 32'(issue_key_o), 32'h0);
        check("rst_issue_data", 32'(issue_data_o), 32'h0);
        check("rst_issue_re", 32'(issue_reinsert_o), 32'h0);
        check("rst_done_valid", 32'(done_valid_o), 32'h0);
        check("rst_done_fail", 32'(done_fail_o), 32'h0);
        check("rst_done_key", 32'(done_key_o), 32'h0);
        check("rst_done_data", 32'(done_data_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);

        // Round-robin LOOKUP/DELETE, back-to-back issues.
        reset = 1'b0;
        req_op_i[0] = LOOKUP; req_key_i[0] = 2'd1; req_data_i[0] = 4'h0;
        req_op_i[1] = DELETE; req_key_i[1] = 2'd2; req_data_i[1] = 4'h0;
        #1;
        check("rr_grant_a", 32'(req_ready_o), 32'h1);
        push_iss(LOOKUP, 2'd1, 4'h0, 1'b0, cyc + 1);
        tick();
        req_key_i[0] = 2'd0;
        #1;
        check("rr_grant_b", 32'(req_ready_o), 32'h2);
        push_iss(DELETE, 2'd2, 4'h0, 1'b0, cyc + 1);
        tick();
        req_valid_i = 2'b01;
        #1;
        check("rr_grant_c", 32'(req_ready_o), 32'h1);
        push_iss(LOOKUP, 2'd0, 4'h0, 1'b0, cyc + 1);
        tick();
        req_valid_i = '0;
        check("lookup_not_busy", 32'(busy_o), 32'h0);
        evict(2'd3, 4'h3);
        repeat (3) tick();

        // Insert, no eviction: success after the full window.
        single_req(0, INSERT, 2'd3, 4'hA, t);
        push_done(1'b0, 2'd3, 4'hA, t + PD + 2);
        check("wait_busy", 32'(busy_o), 32'h1);
        req_valid_i = 2'b10; req_op_i[1] = LOOKUP;
        #1;
        check("wait_no_grant", 32'(req_ready_o), 32'h0);
        req_valid_i = '0;
        wait_until(t + 10);

        // Eviction on the last window cycle, then a clean second window.
        single_req(1, INSERT, 2'd0, 4'h3, t);
        push_iss(INSERT, 2'd1, 4'h5, 1'b1, t + 6);
        push_done(1'b0, 2'd0, 4'h3, t + 11);
        wait_until(t + 4);
        evict(2'd1, 4'h5);
        wait_until(t + 14);

        // Evict every window: third eviction exceeds MAX_KICKS=2.
        single_req(0, INSERT, 2'd2, 4'h9, t);
        push_iss(INSERT, 2'd3, 4'h1, 1'b1, t + 3);
        push_iss(INSERT, 2'd0, 4'h2, 1'b1, t + 5);
        push_done(1'b1, 2'd2, 4'h7, t + 7);
        wait_until(t + 1);
        evict(2'd3, 4'h1);
        evict(2'd0, 4'hF);
        evict(2'd0, 4'h2);
        tick();
        evict(2'd2, 4'h7);
        wait_until(t + 10);
        check("fail_idle", 32'(busy_o), 32'h0);

        // clk_en low for three WAIT cycles delays done by three; evict then ignored.
        single_req(1, INSERT, 2'd1, 4'hC, t);
        push_done(1'b0, 2'd1, 4'hC, t + PD + 2 + 3);
        wait_until(t + 2);
        clk_en = 1'b0;
        tick();
        evict_valid_i = 1'b1; evict_key_i = 2'd0; evict_data_i = 4'h0;
        tick();
        evict_valid_i = 1'b0;
        check("frozen_busy", 32'(busy_o), 32'h1);
        tick();
        clk_en = 1'b1;
        wait_until(t + 12);

        // Reset during REISSUE drops the chain; pointer back at requester 0.
        single_req(0, INSERT, 2'd3, 4'hF, t);
        wait_until(t + 1);
        evict(2'd2, 4'h4);
        reset = 1'b1;
        tick();
        check("abort_issue_valid", 32'(issue_valid_o), 32'h0);
        check("abort_issue_key", 32'(issue_key_o), 32'h0);
        check("abort_issue_data", 32'(issue_data_o), 32'h0);
        check("abort_done_valid", 32'(done_valid_o), 32'h0);
        check("abort_busy", 32'(busy_o), 32'h0);
        reset = 1'b0;
        req_valid_i = 2'b11;
        req_op_i[0] = LOOKUP; req_key_i[0] = 2'd3; req_data_i[0] = 4'h0;
        req_op_i[1] = DELETE; req_key_i[1] = 2'd1; req_data_i[1] = 4'h0;
        #1;
        check("post_rst_grant", 32'(req_ready_o), 32'h1);
        push_iss(LOOKUP, 2'd3, 4'h0, 1'b0, cyc + 1);
        tick();
        req_valid_i = 2'b10;
        #1;
        check("post_rst_grant2", 32'(req_ready_o), 32'h2);
        push_iss(DELETE, 2'd1, 4'h0, 1'b0, cyc + 1);
        tick();
        req_valid_i = '0;
        repeat (5) tick();

        check("iss_q_drained", 32'(iss_q.size()), 32'h0);
        check("done_q_drained", 32'(done_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
